// File: rtl/multi_timer.sv
// multi_timer: NCH independent programmable tick counters with half/full
// strobes, one-shot mode and sticky interrupt flags, behind a single-cycle
// register write port and a combinational read port.
module multi_timer #(
  parameter int               NCH          = 2,
  parameter int               BITS         = 24,
  parameter int               RESET_PERIOD = 2812,
  parameter logic [NCH-1:0]   EN_RESET     = '1,
  localparam int              CHW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [CHW-1:0]  wr_ch,
  input  logic [1:0]      wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic [CHW-1:0]  rd_ch,
  input  logic [1:0]      rd_addr,
  output logic [BITS-1:0] rd_data,
  output logic [NCH-1:0]  half,
  output logic [NCH-1:0]  full,
  output logic [NCH-1:0]  irq
);

  logic [BITS-1:0] cnt    [NCH];
  logic [BITS-1:0] period [NCH];
  logic [NCH-1:0]  en;
  logic [NCH-1:0]  oneshot;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [BITS-1:0] cnt_q;
    logic [BITS-1:0] per_q;
    logic            en_q;
    logic            os_q;
    logic            irq_q;
    logic [BITS-1:0] peff;
    logic [BITS-1:0] inc;
    logic [BITS-1:0] nxt;
    logic            hit;

    // A programmed period of 0 is treated as 1 so the channel still ticks.
    assign peff = (per_q == '0) ? BITS'(1) : per_q;
    assign inc  = cnt_q + BITS'(1);
    assign nxt  = (inc < peff) ? inc : '0;
    assign hit  = wr_en && (wr_ch == CHW'(g));

    assign full[g] = en_q && (cnt_q == peff - BITS'(1));
    assign half[g] = en_q && (cnt_q == (peff >> 1));

    assign cnt[g]     = cnt_q;
    assign period[g]  = per_q;
    assign en[g]      = en_q;
    assign oneshot[g] = os_q;
    assign irq[g]     = irq_q;

    // Channel state: counting first, then an addressed write overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        per_q <= BITS'(RESET_PERIOD);
        en_q  <= EN_RESET[g];
        os_q  <= 1'b0;
        irq_q <= 1'b0;
      end else begin
        // Set has priority over a coincident clear so no terminal event is lost.
        if (full[g]) begin
          irq_q <= 1'b1;
        end else if (hit && wr_addr == 2'd2 && wr_data[0]) begin
          irq_q <= 1'b0;
        end

        if (en_q) begin
          cnt_q <= nxt;
          if (full[g] && os_q) begin
            en_q <= 1'b0;
          end
        end

        if (hit) begin
          case (wr_addr)
            2'd0: begin
              per_q <= wr_data;
              cnt_q <= '0;
            end
            2'd1: begin
              en_q  <= wr_data[0];
              os_q  <= wr_data[1];
              cnt_q <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Read mux; unmatched channel numbers fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == CHW'(i)) begin
        case (rd_addr)
          2'd0:    rd_data = period[i];
          2'd1:    rd_data = {{(BITS-2){1'b0}}, oneshot[i], en[i]};
          2'd2:    rd_data = {{(BITS-1){1'b0}}, irq[i]};
          default: rd_data = cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: three channels (so channel 3 is out of range),
// reference model of the counting rules, directed table, random traffic.
module tb_multi_timer;
  localparam int NCH  = 3;
  localparam int BITS = 24;
  localparam int RP   = 2812;
  localparam int CHW  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [CHW-1:0]  wr_ch = '0;
  logic [1:0]      wr_addr = '0;
  logic [BITS-1:0] wr_data = '0;
  logic [CHW-1:0]  rd_ch = '0;
  logic [1:0]      rd_addr = '0;
  logic [BITS-1:0] rd_data;
  logic [NCH-1:0]  half, full, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_timer #(.NCH(NCH), .BITS(BITS), .RESET_PERIOD(RP), .EN_RESET(3'b111)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
    .half(half), .full(full), .irq(irq));

  // Reference model
  int m_cnt [NCH];
  int m_per [NCH];
  bit m_en  [NCH];
  bit m_os  [NCH];
  bit m_irq [NCH];

  logic [NCH-1:0]  obs_full, obs_half, obs_irq;
  logic [BITS-1:0] obs_rd;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_per[i] = RP; m_en[i] = 1; m_os[i] = 0; m_irq[i] = 0;
    end
  endtask

  function automatic int m_p(input int i);
    return (m_per[i] == 0) ? 1 : m_per[i];
  endfunction

  function automatic int m_read(input int ch, input int a);
    if (ch >= NCH) return 0;
    case (a)
      0: return m_per[ch];
      1: return 2 * int'(m_os[ch]) + int'(m_en[ch]);
      2: return int'(m_irq[ch]);
      default: return m_cnt[ch];
    endcase
  endfunction

  // One clock: drive, check pre-edge outputs against model, advance model.
  task automatic cycle(input bit w, input int ch, input int a, input int d,
                       input int rc, input int ra);
    logic [NCH-1:0] ef, eh, ei;
    wr_en = w; wr_ch = CHW'(ch); wr_addr = 2'(a); wr_data = BITS'(d);
    rd_ch = CHW'(rc); rd_addr = 2'(ra);
    #1;
    for (int i = 0; i < NCH; i++) begin
      ef[i] = m_en[i] && (m_cnt[i] == m_p(i) - 1);
      eh[i] = m_en[i] && (m_cnt[i] == m_p(i) / 2);
      ei[i] = m_irq[i];
    end
    obs_full = full; obs_half = half; obs_irq = irq; obs_rd = rd_data;
    chk("full", int'(full), int'(ef));
    chk("half", int'(half), int'(eh));
    chk("irq", int'(irq), int'(ei));
    chk("rd_data", int'(rd_data), m_read(rc, ra));
    for (int i = 0; i < NCH; i++) begin
      bit wi;
      wi = w && (ch == i);
      if (ef[i]) m_irq[i] = 1;
      else if (wi && a == 2 && d[0]) m_irq[i] = 0;
      if (m_en[i]) begin
        m_cnt[i] = (m_cnt[i] + 1 < m_p(i)) ? m_cnt[i] + 1 : 0;
        if (ef[i] && m_os[i]) m_en[i] = 0;
      end
      if (wi && a == 0) begin
        m_per[i] = d & 24'hFFFFFF; m_cnt[i] = 0;
      end
      if (wi && a == 1) begin
        m_en[i] = d[0]; m_os[i] = d[1]; m_cnt[i] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit w; int ch; int a; int d; int rc; int ra;
    int erd; bit ef; bit eh; bit ei;
  } vec_t;
  vec_t tbl [20];

  initial begin
    int first_full, first_half, nfull;

    // Directed table for channel 1, starting from reset state.
    tbl[0]  = '{1,1,0,3, 1,0,2812, 0,0,0};
    tbl[1]  = '{1,1,1,1, 1,3,0,    0,0,0};
    tbl[2]  = '{0,0,0,0, 1,1,1,    0,0,0};
    tbl[3]  = '{0,0,0,0, 1,3,1,    0,1,0};
    tbl[4]  = '{0,0,0,0, 1,3,2,    1,0,0};
    tbl[5]  = '{1,1,2,1, 1,2,1,    0,0,1};
    tbl[6]  = '{0,0,0,0, 1,2,0,    0,1,0};
    tbl[7]  = '{1,1,2,1, 1,2,0,    1,0,0};
    tbl[8]  = '{0,0,0,0, 1,2,1,    0,0,1};
    tbl[9]  = '{1,1,1,3, 1,1,1,    0,1,1};
    tbl[10] = '{0,0,0,0, 1,1,3,    0,0,1};
    tbl[11] = '{0,0,0,0, 1,3,1,    0,1,1};
    tbl[12] = '{0,0,0,0, 1,1,3,    1,0,1};
    tbl[13] = '{0,0,0,0, 1,1,2,    0,0,1};
    tbl[14] = '{1,3,0,7, 3,0,0,    0,0,1};
    tbl[15] = '{1,1,0,0, 1,3,0,    0,0,1};
    tbl[16] = '{1,1,1,1, 1,0,0,    0,0,1};
    tbl[17] = '{0,0,0,0, 1,3,0,    1,1,1};
    tbl[18] = '{1,1,1,0, 1,3,0,    1,1,1};
    tbl[19] = '{0,0,0,0, 1,1,0,    0,0,1};

    // Free run with default period on channel 0.
    do_reset();
    first_full = -1; first_half = -1; nfull = 0;
    for (int k = 0; k < 2 * RP + 4; k++) begin
      cycle(0, 0, 0, 0, 0, 3);
      if (obs_full[0]) begin
        nfull++;
        if (first_full < 0) first_full = k;
      end
      if (obs_half[0] && first_half < 0) first_half = k;
      if (k == RP - 1) chk("irq0_before_full", int'(obs_irq[0]), 0);
      if (k == RP) chk("irq0_after_full", int'(obs_irq[0]), 1);
    end
    chk("first_full_cycle", first_full, RP - 1);
    chk("first_half_cycle", first_half, RP / 2);
    chk("full_pulse_count", nfull, 2);

    // Table-driven directed sequence.
    do_reset();
    for (int r = 0; r < 20; r++) begin
      cycle(tbl[r].w, tbl[r].ch, tbl[r].a, tbl[r].d, tbl[r].rc, tbl[r].ra);
      chk($sformatf("tbl%0d_full", r), int'(obs_full[1]), int'(tbl[r].ef));
      chk($sformatf("tbl%0d_half", r), int'(obs_half[1]), int'(tbl[r].eh));
      chk($sformatf("tbl%0d_irq", r), int'(obs_irq[1]), int'(tbl[r].ei));
      chk($sformatf("tbl%0d_rd", r), int'(obs_rd), tbl[r].erd);
    end
    chk("oob_no_effect_ch0_per", m_read(0, 0), RP);

    // Periodic ch1 period 5: full on cycles 5, 10, 15 after the control write.
    cycle(1, 1, 0, 5, 1, 3);
    cycle(1, 1, 1, 1, 1, 3);
    nfull = 0;
    for (int k = 1; k <= 15; k++) begin
      cycle(0, 0, 0, 0, 1, 3);
      if (obs_full[1]) begin
        nfull++;
        chk("p5_full_spacing", k % 5, 0);
      end
    end
    chk("p5_full_count", nfull, 3);

    // Randomised traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      int a;
      a = $urandom_range(0, 3);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3), a,
            (a == 0) ? $urandom_range(0, 9) : $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Asynchronous reset between edges, mid-count.
    cycle(1, 1, 0, 5, 1, 3);
    cycle(1, 1, 1, 1, 1, 3);
    repeat (8) cycle(0, 0, 0, 0, 1, 3);
    chk("pre_reset_irq1", int'(obs_irq[1]), 1);
    #1 rst_n = 1'b0;
    rd_ch = 2'd1; rd_addr = 2'd3;
    #1 chk("async_cnt", int'(rd_data), 0);
    rd_addr = 2'd0;
    #1 chk("async_period", int'(rd_data), RP);
    chk("async_irq", int'(irq), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle(0, 0, 0, 0, 1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
